// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter sharing one single-port Memory between two bus masters.
// One transaction at a time: IDLE -> ACCESS -> WAIT (reads, READ_LATENCY cycles) -> RESP -> IDLE.
module memory_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0] m0_write_data,
    output logic [DATA_WIDTH-1:0] m0_read_data,
    output logic                  m0_ack,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0] m1_write_data,
    output logic [DATA_WIDTH-1:0] m1_read_data,
    output logic                  m1_ack,
    output logic                  memory_read,
    output logic                  memory_write,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [3:0] LAT = 4'(READ_LATENCY);

    state_t     state, state_next;
    logic       grant_q, write_q, last_grant;
    logic [3:0] cnt;
    logic       req0, req1, grant_sel, capture;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;
    assign busy = (state != IDLE);

    // Strobes are decoded from state so an async reset drops them immediately.
    always_comb begin
        state_next   = state;
        grant_sel    = 1'b0;
        capture      = 1'b0;
        memory_read  = 1'b0;
        memory_write = 1'b0;
        case (state)
            IDLE: begin
                grant_sel = (req0 && req1) ? ~last_grant : req1;
                if (req0 || req1) state_next = ACCESS;
            end
            ACCESS: begin
                memory_write = write_q;
                memory_read  = ~write_q;
                if (write_q) begin
                    state_next = RESP;
                end else if (LAT == 4'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            grant_q      <= 1'b0;
            write_q      <= 1'b0;
            last_grant   <= 1'b1;
            cnt          <= '0;
            address      <= '0;
            write_data   <= '0;
            m0_read_data <= '0;
            m1_read_data <= '0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
        end else begin
            state  <= state_next;
            m0_ack <= (state_next == RESP) && !grant_q;
            m1_ack <= (state_next == RESP) && grant_q;
            if (state == IDLE && state_next == ACCESS) begin
                grant_q    <= grant_sel;
                last_grant <= grant_sel;
                write_q    <= grant_sel ? m1_write      : m0_write;
                address    <= grant_sel ? m1_address    : m0_address;
                write_data <= grant_sel ? m1_write_data : m0_write_data;
            end
            if (state == ACCESS)
                cnt <= LAT;
            else if (state == WAIT)
                cnt <= cnt - 4'd1;
            if (capture) begin
                if (grant_q) m1_read_data <= read_data;
                else         m0_read_data <= read_data;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed transactions push expected acks, a monitor checks them.
`timescale 1ns/1ps
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_read = 1'b0, m0_write = 1'b0;
    logic [31:0] m0_address = '0, m0_write_data = '0, m0_read_data;
    logic        m0_ack;
    logic        m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m1_address = '0, m1_write_data = '0, m1_read_data;
    logic        m1_ack;
    logic        memory_read, memory_write, busy;
    logic [31:0] address, write_data, read_data;

    typedef struct {
        int          m;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          rd_strobes = 0;
    int          wr_strobes = 0;
    logic [31:0] mem [256];
    logic [31:0] rd_q = '0;

    memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_write_data(m0_write_data), .m0_read_data(m0_read_data), .m0_ack(m0_ack),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_write_data(m1_write_data), .m1_read_data(m1_read_data), .m1_ack(m1_ack),
        .memory_read(memory_read), .memory_write(memory_write),
        .address(address), .write_data(write_data), .read_data(read_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data registered at the edge ending the read strobe cycle.
    assign read_data = rd_q;
    always @(posedge clk) begin
        if (memory_read) rd_q <= mem[address[7:0]];
        if (memory_write) mem[address[7:0]] = write_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever an ack is presented.
    always @(negedge clk) begin
        rd_strobes += int'(memory_read);
        wr_strobes += int'(memory_write);
        if (m0_ack && m1_ack) check("dual_ack", 1, 0);
        else if (m0_ack || m1_ack) begin
            if (exp_q.size() == 0) check("sb_underflow", 0, 1);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_master", m1_ack ? 1 : 0, 64'(e.m));
                check(e.rd ? "read_data" : "held_read_data", m1_ack ? m1_read_data : m0_read_data, e.data);
            end
        end
    end

    // Call at posedge+#1; returns at posedge+#1 after the ack cycle with the request dropped.
    task automatic master_txn(input int m, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
        int start;
        bit done;
        done = 0;
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = addr; m0_write_data = wdata;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = addr; m1_write_data = wdata;
        end
        start = cyc;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ack : m1_ack) begin
                if (exp_lat >= 0) check("ack_latency", 64'(cyc - start), 64'(exp_lat));
                done = 1;
            end
        end
        if (!done) check("ack_timeout", 0, 1);
        @(posedge clk); #1;
        if (m == 0) begin m0_read = 0; m0_write = 0; end
        else        begin m1_read = 0; m1_write = 0; end
    endtask

    task automatic push(input int m, input bit rd, input logic [31:0] data);
        exp_t e;
        e.m = m; e.rd = rd; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int rs, ws;
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        for (int k = 0; k < 6; k++) mem[8'h40 + k] = 32'h1111_0000 + 32'(k);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_strobes", {memory_read, memory_write}, 0);
        check("rst_acks", {m0_ack, m1_ack}, 0);
        check("rst_addr", address, 0);
        check("rst_rdata", {m0_read_data, m1_read_data}, 0);
        @(posedge clk); #1 reset = 1'b0;

        // 1: m0 read 0x10
        rs = rd_strobes; ws = wr_strobes;
        push(0, 1, 32'hDEADBEEF);
        master_txn(0, 1, 0, 32'h10, 32'h0, 3);
        check("t1_read_strobes", 64'(rd_strobes - rs), 1);
        check("t1_write_strobes", 64'(wr_strobes - ws), 0);
        check("t1_addr_held", address, 32'h10);

        // 2: m1 write 0x20, then m0 reads it back
        push(1, 0, 32'h0);
        master_txn(1, 0, 1, 32'h20, 32'h12345678, 2);
        push(0, 1, 32'h12345678);
        master_txn(0, 1, 0, 32'h20, 32'h0, 3);

        // 3: simultaneous reads right after reset, m0 first
        pulse_reset();
        push(0, 1, 32'hDEADBEEF);
        push(1, 1, 32'h12345678);
        fork
            master_txn(0, 1, 0, 32'h10, 32'h0, -1);
            master_txn(1, 1, 0, 32'h20, 32'h0, -1);
        join

        // 4: continuous contention alternates grants
        for (int k = 0; k < 6; k++) push(k % 2, 1, 32'h1111_0000 + 32'(k));
        fork
            for (int k = 0; k < 3; k++) master_txn(0, 1, 0, 32'h40 + 32'(2 * k), 32'h0, -1);
            for (int k = 0; k < 3; k++) master_txn(1, 1, 0, 32'h41 + 32'(2 * k), 32'h0, -1);
        join

        // 5: reset during WAIT of an m1 read aborts it
        m1_read = 1; m1_address = 32'h10;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (memory_read) seen = 1;
        end
        if (!seen) check("t5_strobe_timeout", 0, 1);
        @(posedge clk); #2 reset = 1'b1;
        #1;
        check("t5_abort_strobes", {memory_read, memory_write}, 0);
        check("t5_abort_acks", {m0_ack, m1_ack}, 0);
        check("t5_abort_busy", busy, 0);
        m1_read = 0;
        @(posedge clk); #1 reset = 1'b0;
        push(0, 1, 32'h1111_0000);
        push(1, 1, 32'h1111_0001);
        fork
            master_txn(0, 1, 0, 32'h40, 32'h0, -1);
            master_txn(1, 1, 0, 32'h41, 32'h0, -1);
        join

        // 6: read+write together is a write
        rs = rd_strobes; ws = wr_strobes;
        push(0, 0, 32'h1111_0000);
        master_txn(0, 1, 1, 32'h30, 32'hA5A5A5A5, 2);
        check("t6_read_strobes", 64'(rd_strobes - rs), 0);
        check("t6_write_strobes", 64'(wr_strobes - ws), 1);
        check("t6_mem", mem[8'h30], 32'hA5A5A5A5);
        check("t6_wdata_held", write_data, 32'hA5A5A5A5);

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
